// File: rtl/uart_tx_rr_arbiter.sv
// Round-robin, packet-granular scheduler sharing one 8N1 transmitter among
// NUM_REQ byte-stream requesters; one byte in flight at a time.
module uart_tx_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Req_Ready,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy
);
    // state     | meaning
    // s_IDLE    | no owner; arbitrate among valid requesters starting at ptr
    // s_LOAD    | owner holds grant; issue its byte once transmitter is idle
    // s_WAIT_TX | byte issued; wait for the transmitter done pulse
    // s_NEXT    | release grant and move ptr past the owner
    typedef enum logic [1:0] {s_IDLE, s_LOAD, s_WAIT_TX, s_NEXT} state_t;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = 8;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               last, last_nxt;
    logic [NUM_REQ-1:0] grant_nxt, ready_nxt;
    logic               tx_dv_nxt, busy_nxt;
    logic [7:0]         tx_byte_nxt;

    logic               pick_found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W:0]     cand;
    logic               owner_valid, owner_last, burst_end;
    logic [7:0]         owner_byte;
    logic [IDX_W-1:0]   owner_succ;

    // first valid requester scanning ptr, ptr+1, ... modulo NUM_REQ
    always_comb begin
        pick       = ptr;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!pick_found && i_Req_Valid[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick       = cand[IDX_W-1:0];
            end
        end
    end

    assign owner_valid = i_Req_Valid[owner];
    assign owner_last  = i_Req_Last[owner];
    assign owner_byte  = i_Req_Byte[{owner, 3'b000} +: 8];
    assign burst_end   = last || (cnt == CNT_W'(MAX_BURST));
    assign owner_succ  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= s_IDLE;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            last        <= 1'b0;
            o_Grant     <= '0;
            o_Req_Ready <= '0;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= 8'h00;
            o_Busy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            owner       <= owner_nxt;
            cnt         <= cnt_nxt;
            last        <= last_nxt;
            o_Grant     <= grant_nxt;
            o_Req_Ready <= ready_nxt;
            o_Tx_DV     <= tx_dv_nxt;
            o_Tx_Byte   <= tx_byte_nxt;
            o_Busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            s_IDLE:    if (pick_found) state_nxt = s_LOAD;
            s_LOAD: begin
                if (!owner_valid)      state_nxt = s_NEXT;
                else if (!i_Tx_Active) state_nxt = s_WAIT_TX;
            end
            s_WAIT_TX: if (i_Tx_Done) state_nxt = burst_end ? s_NEXT : s_LOAD;
            s_NEXT:    state_nxt = s_IDLE;
            default:   state_nxt = s_IDLE;
        endcase
    end

    always_comb begin
        grant_nxt   = o_Grant;
        ready_nxt   = '0;
        tx_dv_nxt   = 1'b0;
        tx_byte_nxt = o_Tx_Byte;
        ptr_nxt     = ptr;
        owner_nxt   = owner;
        cnt_nxt     = cnt;
        last_nxt    = last;
        busy_nxt    = (state_nxt != s_IDLE);
        case (state)
            s_IDLE: begin
                if (pick_found) begin
                    grant_nxt = NUM_REQ'(1) << pick;
                    owner_nxt = pick;
                    cnt_nxt   = '0;
                    last_nxt  = 1'b0;
                end
            end
            s_LOAD: begin
                if (owner_valid && !i_Tx_Active) begin
                    tx_byte_nxt = owner_byte;
                    tx_dv_nxt   = 1'b1;
                    ready_nxt   = o_Grant;
                    last_nxt    = owner_last;
                    cnt_nxt     = cnt + CNT_W'(1);
                end
            end
            s_NEXT: begin
                grant_nxt = '0;
                ptr_nxt   = owner_succ;
            end
            default: ;
        endcase
    end
endmodule
